// File: rtl/axi_axis_read_mux.sv
// AXI4-Lite read slave that pops one word from a selected AXIS channel per read,
// with a status register reporting tvalid flags and a saturating empty-read counter.
module axi_axis_read_mux #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int NUM_CHANNELS   = 4
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [AXI_ADDR_WIDTH-1:0]              s_axi_araddr,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]              s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic                                   s_axi_rvalid,
  input  logic                                   s_axi_rready,
  input  logic [NUM_CHANNELS*AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CHANNELS-1:0]                s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]                s_axis_tready
);

  localparam int         CB          = $clog2(NUM_CHANNELS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t                    r_state;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp;
  logic [15:0]               r_empty_cnt;

  logic [CB-1:0]             w_sel;
  logic                      w_stat;
  logic                      w_sel_ok;
  logic                      w_sel_tvalid;
  logic [AXI_DATA_WIDTH-1:0] w_sel_data;
  logic                      w_ar_hs;
  logic                      w_pop;
  logic [31:0]               w_status;
  logic [15:0]               w_cnt_inc;
  logic                      w_unused_addr;

  assign w_sel         = s_axi_araddr[2 +: CB];
  assign w_stat        = s_axi_araddr[2 + CB];
  assign w_unused_addr = ^s_axi_araddr;
  assign w_sel_ok      = (int'(w_sel) < NUM_CHANNELS);
  assign w_sel_tvalid  = |(s_axis_tvalid & (NUM_CHANNELS'(1) << w_sel));
  assign w_sel_data    = s_axis_tdata[int'(w_sel)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];

  // Reset gates the handshake so no tready can fire while areset is high.
  assign w_ar_hs = (r_state == ST_IDLE) && s_axi_arvalid && !areset;
  assign w_pop   = w_ar_hs && !w_stat && w_sel_ok && w_sel_tvalid;

  assign s_axis_tready = w_pop ? (NUM_CHANNELS'(1) << w_sel) : '0;

  assign w_status  = {r_empty_cnt, 16'(s_axis_tvalid)};
  assign w_cnt_inc = (r_empty_cnt == 16'hFFFF) ? r_empty_cnt : r_empty_cnt + 16'd1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
      r_empty_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_axi_arvalid) begin
            r_state <= ST_RESP;
            if (w_stat) begin
              r_rdata     <= AXI_DATA_WIDTH'(w_status);
              r_rresp     <= RESP_OKAY;
              r_empty_cnt <= '0;
            end else if (!w_sel_ok) begin
              r_rdata <= '0;
              r_rresp <= RESP_SLVERR;
            end else if (w_sel_tvalid) begin
              r_rdata <= w_sel_data;
              r_rresp <= RESP_OKAY;
            end else begin
              r_rdata     <= '0;
              r_rresp     <= RESP_OKAY;
              r_empty_cnt <= w_cnt_inc;
            end
          end
        end
        ST_RESP: begin
          // Response registers hold untouched until the master accepts.
          if (s_axi_rready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axi_arready = (r_state == ST_IDLE);
  assign s_axi_rvalid  = (r_state == ST_RESP);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_axis_read_mux.sv
// Randomized self-checking bench for axi_axis_read_mux: a 4-channel and a 3-channel
// instance share the AXI master and stream sources and are compared to a read model.
module tb_axi_axis_read_mux;

  logic         aclk = 1'b0;
  logic         areset;
  logic [15:0]  araddr;
  logic         arvalid;
  logic         rready;
  logic [3:0]   tvalid;
  logic [127:0] tdata;

  logic         arready4, rvalid4, arready3, rvalid3;
  logic [31:0]  rdata4, rdata3;
  logic [1:0]   rresp4, rresp3;
  logic [3:0]   tready4;
  logic [2:0]   tready3;

  int n_chk = 0;
  int n_err = 0;
  int cnt4  = 0;
  int cnt3  = 0;

  always #5 aclk = ~aclk;

  axi_axis_read_mux #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .NUM_CHANNELS(4)) dut4 (
    .aclk(aclk), .areset(areset),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready4),
    .s_axi_rdata(rdata4), .s_axi_rresp(rresp4), .s_axi_rvalid(rvalid4), .s_axi_rready(rready),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready4)
  );

  axi_axis_read_mux #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .NUM_CHANNELS(3)) dut3 (
    .aclk(aclk), .areset(areset),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready3),
    .s_axi_rdata(rdata3), .s_axi_rresp(rresp3), .s_axi_rvalid(rvalid3), .s_axi_rready(rready),
    .s_axis_tdata(tdata[95:0]), .s_axis_tvalid(tvalid[2:0]), .s_axis_tready(tready3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one read on an n-channel mux, from the address-decode rules.
  function automatic void model(input int n, input logic [15:0] addr, input logic [7:0] tv,
                                input logic [255:0] td, inout int cnt,
                                output logic [31:0] d, output logic [1:0] r, output logic [7:0] tr);
    int cb, sel, stat;
    cb = 0;
    while ((1 << cb) < n) cb++;
    sel  = int'(addr >> 2) % (1 << cb);
    stat = int'(addr >> (2 + cb)) % 2;
    d = '0; r = 2'b00; tr = '0;
    if (stat == 1) begin
      d   = (32'(cnt) << 16) | 32'(tv & 8'((1 << n) - 1));
      cnt = 0;
    end else if (sel >= n) begin
      r = 2'b10;
    end else if (tv[sel]) begin
      d  = td[sel*32 +: 32];
      tr = 8'(1 << sel);
    end else if (cnt < 65535) begin
      cnt = cnt + 1;
    end
  endfunction

  // Called at posedge+1 with both DUTs idle; returns at posedge+1 with both idle again.
  task automatic do_read(input logic [15:0] addr, input int hold, input bit poke);
    logic [31:0] d4, d3;
    logic [1:0]  r4, r3;
    logic [7:0]  t4, t3;
    model(4, addr, {4'b0, tvalid}, {128'b0, tdata}, cnt4, d4, r4, t4);
    model(3, addr, {5'b0, tvalid[2:0]}, {160'b0, tdata[95:0]}, cnt3, d3, r3, t3);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    #1;
    check("arready4_idle", arready4, 1);
    check("arready3_idle", arready3, 1);
    check("tready4_hs", tready4, t4[3:0]);
    check("tready3_hs", tready3, t3[2:0]);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("rvalid4", rvalid4, 1);
    check("rdata4", rdata4, d4);
    check("rresp4", rresp4, r4);
    check("tready4_after", tready4, 0);
    check("rvalid3", rvalid3, 1);
    check("rdata3", rdata3, d3);
    check("rresp3", rresp3, r3);
    check("tready3_after", tready3, 0);
    for (int i = 0; i < hold; i++) begin
      tvalid = 4'($urandom);
      tdata  = {$urandom, $urandom, $urandom, $urandom};
      if (poke) begin
        arvalid = 1'b1;
        araddr  = 16'($urandom);
      end
      #1;
      check("tready4_hold", tready4, 0);
      check("tready3_hold", tready3, 0);
      check("arready4_hold", arready4, 0);
      @(posedge aclk); #1;
      check("rvalid4_hold", rvalid4, 1);
      check("rdata4_hold", rdata4, d4);
      check("rresp4_hold", rresp4, r4);
      check("rdata3_hold", rdata3, d3);
    end
    arvalid = 1'b0; rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    check("rvalid4_done", rvalid4, 0);
    check("arready4_done", arready4, 1);
    check("rvalid3_done", rvalid3, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1; araddr = '0; arvalid = 1'b1; rready = 1'b0;
    tvalid = 4'hF; tdata = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge aclk);
    #1;
    check("rst_rvalid4", rvalid4, 0);
    check("rst_arready4", arready4, 1);
    check("rst_rdata4", rdata4, 0);
    check("rst_rresp4", rresp4, 0);
    check("rst_tready4", tready4, 0);
    check("rst_tready3", tready3, 0);
    areset = 1'b0; arvalid = 1'b0;
    @(posedge aclk); #1;

    // Single channel read from channel 2.
    tvalid = 4'b0100;
    tdata  = '0;
    tdata[64 +: 32] = 32'hCAFE0002;
    do_read(16'h0008, 0, 1'b0);
    check("chan2_data", rdata4, 32'hCAFE0002);

    // Three empty reads then two status reads.
    tvalid = 4'b0000;
    repeat (3) do_read(16'h0004, 0, 1'b0);
    do_read(16'h0010, 0, 1'b0);
    check("status_cnt3", rdata4, 32'h0003_0000);
    do_read(16'h0010, 0, 1'b0);
    check("status_cleared", rdata4[31:16], 16'h0000);

    // Backpressure with a competing arvalid during the stall.
    tvalid = 4'b0001;
    tdata  = {$urandom, $urandom, $urandom, $urandom};
    do_read(16'h0000, 5, 1'b1);

    // Channel 3: out of range on the 3-channel instance.
    tvalid = 4'b0000;
    do_read(16'h0004, 0, 1'b0);
    tvalid = 4'b1111;
    do_read(16'h000C, 0, 1'b0);
    check("inv_resp3", rresp3, 2'b10);
    check("inv_data3", rdata3, 0);
    do_read(16'h0010, 0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      tvalid = 4'($urandom);
      tdata  = {$urandom, $urandom, $urandom, $urandom};
      do_read(16'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Counter saturation from a preloaded value close to the top.
    tvalid = 4'b0000;
    do_read(16'h0010, 0, 1'b0);
    force dut4.r_empty_cnt = 16'hFFF0;
    #1;
    release dut4.r_empty_cnt;
    cnt4 = 16'hFFF0;
    repeat (20) do_read(16'h0004, 0, 1'b0);
    do_read(16'h0010, 0, 1'b0);
    check("sat_hi", rdata4[31:16], 16'hFFFF);

    // Reset while a popped word is awaiting acceptance.
    do_read(16'h0004, 0, 1'b0);
    tvalid = 4'b0001;
    araddr = 16'h0000; arvalid = 1'b1;
    #1;
    check("rstresp_pop4", tready4, 4'b0001);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("rstresp_rvalid_pre", rvalid4, 1);
    areset = 1'b1;
    #1;
    check("rstresp_tready4", tready4, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    check("rstresp_rvalid4", rvalid4, 0);
    check("rstresp_arready4", arready4, 1);
    check("rstresp_rvalid3", rvalid3, 0);
    cnt4 = 0; cnt3 = 0;
    tvalid = 4'b0000;
    do_read(16'h0010, 0, 1'b0);
    check("rstresp_cnt", rdata4[31:16], 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_axis_read_mux.md
AXI_AXIS_READ_MUX -- requirements
Module: axi_axis_read_mux

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, the width of the AXI read data and of each stream word.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 16, the width of the AXI read address.
REQ-003 SHALL have parameter NUM_CHANNELS, default 4, the number of AXIS sources; legal range 2..8.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port s_axi_araddr, input, AXI_ADDR_WIDTH bits: read address.
REQ-007 SHALL have ports s_axi_arvalid (input, 1) and s_axi_arready (output, 1): read-address handshake.
REQ-008 SHALL have port s_axi_rdata, output, AXI_DATA_WIDTH bits: read data.
REQ-009 SHALL have port s_axi_rresp, output, 2 bits: read response.
REQ-010 SHALL have ports s_axi_rvalid (output, 1) and s_axi_rready (input, 1): read-data handshake.
REQ-011 SHALL have port s_axis_tdata, input, NUM_CHANNELS*AXI_DATA_WIDTH bits: channel i occupies bits [i*W +: W].
REQ-012 SHALL have ports s_axis_tvalid (input) and s_axis_tready (output), each NUM_CHANNELS bits: one bit per channel.

Function
REQ-013 SHALL decode the address as follows:
- CB = clog2(NUM_CHANNELS).
- sel = araddr[2+CB-1:2].
- stat = araddr[2+CB].
- All other address bits are ignored.
REQ-014 SHALL implement a two-state FSM:
- IDLE: s_axi_arready=1, s_axi_rvalid=0.
- RESP: s_axi_arready=0, s_axi_rvalid=1.
REQ-015 SHALL, in IDLE with arvalid=1, register rdata/rresp and enter RESP on the next edge; first rvalid appears one cycle after the AR handshake.
REQ-016 SHALL, in RESP, hold rdata and rresp stable until rready=1, then return to IDLE; sustained throughput is one read per two cycles.
REQ-017 SHALL, for a channel read (stat=0, sel<NUM_CHANNELS, tvalid[sel]=1), return tdata[sel] with rresp=2'b00 and assert tready[sel] combinationally in that same IDLE cycle, so the pop coincides with capture.
REQ-018 SHALL, for a channel read with tvalid[sel]=0, return all-zero data with rresp=2'b00, pop nothing, and increment the empty-read counter.
REQ-019 SHALL, for sel>=NUM_CHANNELS with stat=0, return zero data with rresp=2'b10 (SLVERR), pop nothing, and leave the counter unchanged.
REQ-020 SHALL, for a status read (stat=1), return:
- bits[NUM_CHANNELS-1:0] = tvalid snapshot;
- bits[15:NUM_CHANNELS] = 0;
- bits[31:16] = empty-read counter value before the clear.
The response is rresp=2'b00, and the counter clears to 0 in the same cycle.
REQ-021 SHALL keep the empty-read counter at 16 bits, saturating at 16'hFFFF with no wrap.
REQ-022 SHALL hold all tready bits at 0 outside the AR handshake cycle; at most one tready bit is asserted in any cycle.
REQ-023 SHALL ignore arvalid while in RESP: no capture, no pop, no counter change.
REQ-024 SHALL, if a channel's tvalid drops while the read response is pending, leave the already-captured rdata unchanged.

Reset
REQ-025 SHALL, on areset=1 at a clock edge, enter IDLE, clear rvalid, rdata, rresp and the counter to 0, and drive every tready bit to 0 while areset is high.
REQ-026 SHALL, if reset occurs in RESP, discard the pending response; the stream word already popped stays consumed.

Structure
REQ-027 SHALL use no shared package; the state encoding, response codes (OKAY=2'b00, SLVERR=2'b10) and CB SHALL be local constants.
REQ-028 SHALL be a single flat module with no sub-modules; the channel selection SHALL be an indexed part-select, not per-channel instances.

Verification
REQ-029 SHALL cover a channel read: tvalid=4'b0100, tdata[2]=32'hCAFE0002, read 0x0008 -> rvalid next cycle, rdata=32'hCAFE0002, rresp=0, tready=4'b0100 for exactly one cycle.
REQ-030 SHALL cover an empty read: tvalid=0, read 0x0004 three times, then read 0x0010 -> rdata=32'h0003_0000; an immediate second status read returns upper half 0.
REQ-031 SHALL cover backpressure: rready held 0 for 5 cycles after rvalid -> rdata stable, arready=0, and a second arvalid causes no pop; rready=1 -> IDLE the next cycle.
REQ-032 SHALL cover the invalid channel: NUM_CHANNELS=3, read 0x000C -> rresp=2'b10, rdata=0, tready=0, counter unchanged.
REQ-033 SHALL cover saturation: preload by 65,540 empty reads -> status upper half 16'hFFFF.
REQ-034 SHALL cover reset mid-operation: areset=1 while in RESP -> next cycle rvalid=0, arready=1, counter=0.
